thermo_gen_15: RTL and testbench

- Sequential decoder for the 15-input ones counter; it performs the inverse mapping.
- Accepts a 4-bit count N through a valid/ready handshake.
- Builds the matching 15-bit thermometer code (N ones, LSB-aligned) by shifting in one 1 per clock.
- Emits a serial unary pulse per 1 shifted, then presents the finished code through an output valid/ready handshake.
- Feeds pattern generators and self-checking loops around the ones counter: count -> thermometer -> ones counter must return N.

---
 rtl/thermo_pkg.sv | 47 ++++
 rtl/thermo_gen_15_shift.sv | 30 +++
 rtl/thermo_gen_15.sv | 116 +++++++++++
 tb/tb_thermo_gen_15.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/thermo_pkg.sv
// Shared constants, state encoding and helpers for the thermometer-code generator.
package thermo_pkg;

    // Thermometer width: one bit per ones-counter input.
    localparam int WIDTH = 15;

    // Count width, $clog2(WIDTH+1).
    localparam int CW = 4;

    // Handy count constants.
    localparam logic [CW-1:0] CNT_ZERO = 4'd0;
    localparam logic [CW-1:0] CNT_ONE  = 4'd1;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reference thermometer code for a count n: (1<<n)-1, truncated to WIDTH bits.
    function automatic logic [WIDTH-1:0] therm_ref(input logic [CW-1:0] n);
        logic [WIDTH-1:0] r;
        r = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(n)) begin
                r[i] = 1'b1;
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    // Clamp a requested count to the thermometer width. With WIDTH=15 and
    // CW=4 this never saturates, but it keeps the block correct if WIDTH shrinks.
    function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] n);
        logic [CW-1:0] r;
        if (int'(n) > WIDTH) begin
            r = CW'(WIDTH);
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/thermo_gen_15_shift.sv
// WIDTH-bit shift register that fills with ones from bit 0 upward.
// A synchronous clear wins over the shift enable; reset wins over both.
module thermo_gen_15_shift
    import thermo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Shift register: reset/clear to zero, otherwise shift a 1 in at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            q_r <= {WIDTH{1'b0}};
        end else if (shift_en) begin
            q_r <= {q_r[WIDTH-2:0], 1'b1};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/thermo_gen_15.sv
// Sequential count -> thermometer decoder. Accepts a count N on a valid/ready
// handshake, shifts in one 1 per clock (pulsing unary each time), then holds
// the finished code 2^N-1 on an output valid/ready handshake. The last code
// stays on thermo after hand-off until the next count is accepted.
module thermo_gen_15
    import thermo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_count,
    output logic             unary,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] thermo
);

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   rem_r;
    logic [CW-1:0]   rem_s;
    logic [CW-1:0]   req_s;
    logic            clr_s;
    logic            shift_s;

    logic            in_ready_r;
    logic            unary_r;
    logic            busy_r;
    logic            out_valid_r;

    // Next-state, remaining-count and shift-register control decode.
    always_comb begin
        state_s = state_r;
        rem_s   = rem_r;
        clr_s   = 1'b0;
        shift_s = 1'b0;
        req_s   = clamp_count(in_count);
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    clr_s = 1'b1;
                    rem_s = req_s;
                    if (req_s == CNT_ZERO) begin
                        state_s = DONE;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                shift_s = 1'b1;
                rem_s   = rem_r - CNT_ONE;
                if (rem_r == CNT_ONE) begin
                    state_s = DONE;
                end else begin
                    state_s = FILL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                rem_s   = CNT_ZERO;
            end
        endcase
    end

    // State and remaining-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            rem_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            rem_r   <= rem_s;
        end
    end

    // Moore outputs, registered from the next state so they line up with state_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            unary_r     <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == IDLE);
            unary_r     <= (state_s == FILL);
            busy_r      <= (state_s == FILL);
            out_valid_r <= (state_s == DONE);
        end
    end

    thermo_gen_15_shift u_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_s),
        .shift_en (shift_s),
        .q        (thermo)
    );

    assign in_ready  = in_ready_r;
    assign unary     = unary_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_thermo_gen_15.sv
// Self-checking bench for thermo_gen_15: table-driven count sweep plus
// hand-written backpressure, mid-fill reset, and reset-vs-accept sequences.
module tb_thermo_gen_15;
    import thermo_pkg::*;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    in_count;
    logic             unary;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] thermo;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [3:0]  n;
        logic [14:0] exp_thermo;
        int          exp_unary;
        int          exp_lat;
    } vec_t;

    vec_t vecs [16];

    thermo_gen_15 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_count  (in_count),
        .unary     (unary),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .thermo    (thermo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept count n, then watch until out_valid (bounded). Returns the code
    // seen with out_valid, unary/busy cycle counts and edges after accept.
    task automatic run_txn(input logic [3:0] n, output logic [14:0] code,
                           output int ucnt, output int bcnt, output int lat);
        bit seen;
        code = 15'h0000;
        ucnt = 0;
        bcnt = 0;
        lat  = 0;
        seen = 1'b0;
        in_valid = 1'b1;
        in_count = n;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                code = thermo;
                break;
            end
            if (unary === 1'b1) ucnt++;
            if (busy === 1'b1) bcnt++;
            tick();
            lat++;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL txn_timeout: got no out_valid expected out_valid for n=%0d", n);
        end
    endtask

    initial begin
        logic [14:0] code;
        int ucnt, bcnt, lat, ov_seen;

        n_cmp = 0;
        n_err = 0;

        vecs[0]  = '{4'd0,  15'h0000, 0,  0};
        vecs[1]  = '{4'd1,  15'h0001, 1,  1};
        vecs[2]  = '{4'd2,  15'h0003, 2,  2};
        vecs[3]  = '{4'd3,  15'h0007, 3,  3};
        vecs[4]  = '{4'd4,  15'h000F, 4,  4};
        vecs[5]  = '{4'd5,  15'h001F, 5,  5};
        vecs[6]  = '{4'd6,  15'h003F, 6,  6};
        vecs[7]  = '{4'd7,  15'h007F, 7,  7};
        vecs[8]  = '{4'd8,  15'h00FF, 8,  8};
        vecs[9]  = '{4'd9,  15'h01FF, 9,  9};
        vecs[10] = '{4'd10, 15'h03FF, 10, 10};
        vecs[11] = '{4'd11, 15'h07FF, 11, 11};
        vecs[12] = '{4'd12, 15'h0FFF, 12, 12};
        vecs[13] = '{4'd13, 15'h1FFF, 13, 13};
        vecs[14] = '{4'd14, 15'h3FFF, 14, 14};
        vecs[15] = '{4'd15, 15'h7FFF, 15, 15};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_count  = 4'd0;
        out_ready = 1'b1;

        // Reset for two cycles, then release.
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_thermo",    32'(thermo),    32'h0);
        check("reset_in_ready",  32'(in_ready),  32'h1);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_busy",      32'(busy),      32'h0);
        check("reset_unary",     32'(unary),     32'h0);

        // Sweep every count with out_ready held high.
        for (int i = 0; i < 16; i++) begin
            run_txn(vecs[i].n, code, ucnt, bcnt, lat);
            check($sformatf("sweep_thermo_n%0d", i), 32'(code), 32'(vecs[i].exp_thermo));
            check($sformatf("sweep_unary_n%0d", i), 32'(ucnt), 32'(vecs[i].exp_unary));
            check($sformatf("sweep_busy_n%0d", i), 32'(bcnt), 32'(vecs[i].exp_unary));
            check($sformatf("sweep_latency_n%0d", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("loopback_n%0d", i), 32'($countones(code)), 32'(vecs[i].n));
            tick();
            check($sformatf("sweep_idle_n%0d", i), 32'(in_ready), 32'h1);
            check($sformatf("sweep_ov_low_n%0d", i), 32'(out_valid), 32'h0);
            check($sformatf("sweep_hold_n%0d", i), 32'(thermo), 32'(vecs[i].exp_thermo));
        end

        // Backpressure: N=5, consumer stalls 10 cycles while in_valid toggles.
        out_ready = 1'b0;
        run_txn(4'd5, code, ucnt, bcnt, lat);
        check("bp_first_code", 32'(code), 32'h001F);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            in_count = 4'd3;
            tick();
            check($sformatf("bp_out_valid_%0d", k), 32'(out_valid), 32'h1);
            check($sformatf("bp_thermo_%0d", k),    32'(thermo),    32'h001F);
            check($sformatf("bp_in_ready_%0d", k),  32'(in_ready),  32'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready",  32'(in_ready),  32'h1);
        check("bp_release_out_valid", 32'(out_valid), 32'h0);
        check("bp_release_thermo",    32'(thermo),    32'h001F);

        // Reset in the middle of a fill of N=12, after 4 unary cycles.
        ov_seen  = 0;
        ucnt     = 0;
        in_valid = 1'b1;
        in_count = 4'd12;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (unary === 1'b1) ucnt++;
            if (out_valid === 1'b1) ov_seen++;
            if (k < 3) tick();
        end
        check("midrst_unary_before", 32'(ucnt), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_thermo",    32'(thermo),    32'h0);
        check("midrst_busy",      32'(busy),      32'h0);
        check("midrst_unary",     32'(unary),     32'h0);
        check("midrst_in_ready",  32'(in_ready),  32'h1);
        for (int k = 0; k < 12; k++) begin
            if (out_valid === 1'b1) ov_seen++;
            tick();
        end
        check("midrst_no_out_valid", 32'(ov_seen), 32'd0);
        run_txn(4'd2, code, ucnt, bcnt, lat);
        check("midrst_after_thermo", 32'(code), 32'h0003);
        check("midrst_after_unary",  32'(ucnt), 32'd2);
        tick();

        // Reset and accept on the same edge: reset wins, count dropped.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_count = 4'd5;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_vs_valid_busy",     32'(busy),     32'h0);
        check("rst_vs_valid_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("rst_vs_valid_busy2",    32'(busy),     32'h0);
        check("rst_vs_valid_thermo",   32'(thermo),   32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
